// File: rtl/duck_flight_ctrl.sv
// rtl/duck_flight_ctrl.sv - per-frame duck sprite motion and life-cycle controller
module duck_flight_ctrl #(
    parameter int DUCK_W         = 64,
    parameter int DUCK_H         = 64,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 399,
    parameter int STEP_X         = 2,
    parameter int STEP_Y         = 1,
    parameter int FALL_STEP      = 4,
    parameter int HIT_FRAMES     = 30,
    parameter int FLY_TIMEOUT    = 600,
    parameter int RESPAWN_FRAMES = 60,
    parameter int RESPAWN_X      = 288,
    parameter int ANIM_DIV       = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       shoot,
    input  logic [9:0] aim_x,
    input  logic [9:0] aim_y,
    output logic [9:0] duck_x,
    output logic [9:0] duck_y,
    output logic       dir_x,
    output logic [1:0] duck_anim,
    output logic       duck_visible,
    output logic [2:0] state,
    output logic       hit,
    output logic       escaped
);
    localparam logic [10:0] XR     = 11'(X_MAX + 1 - DUCK_W);
    localparam logic [10:0] YF     = 11'(Y_MAX + 1 - DUCK_H);
    localparam logic [10:0] SX     = 11'(STEP_X);
    localparam logic [10:0] SY     = 11'(STEP_Y);
    localparam logic [10:0] FS     = 11'(FALL_STEP);
    localparam logic [10:0] BW     = 11'(DUCK_W - 1);
    localparam logic [10:0] BH     = 11'(DUCK_H - 1);
    localparam logic [9:0]  RX     = 10'(RESPAWN_X);
    localparam logic [15:0] T_FLY  = 16'(FLY_TIMEOUT);
    localparam logic [15:0] T_HIT  = 16'(HIT_FRAMES);
    localparam logic [15:0] T_GONE = 16'(RESPAWN_FRAMES);
    localparam logic [15:0] T_ANIM = 16'(ANIM_DIV - 1);

    typedef enum logic [2:0] {
        S_FLY    = 3'd0,
        S_HIT    = 3'd1,
        S_FALL   = 3'd2,
        S_ESCAPE = 3'd3,
        S_GONE   = 3'd4
    } state_t;

    state_t      st_q, st_d;
    logic [1:0]  vs_sync;
    logic        vs_prev;
    logic        tick;
    logic [9:0]  x_d, y_d, x_fly, y_fly;
    logic [10:0] xw, yw, ax, ay;
    logic        dir_x_d, dir_x_fly, dir_y_up_q, dir_y_up_d, dir_y_fly;
    logic        last_dir_q, last_dir_d;
    logic [1:0]  anim_d, anim_step;
    logic        vis_d, hit_d, esc_d, in_box;
    logic [15:0] cnt_q, cnt_d, cnt_inc, div_q, div_d, div_step;

    assign tick    = vs_sync[1] & ~vs_prev;
    assign xw      = {1'b0, duck_x};
    assign yw      = {1'b0, duck_y};
    assign ax      = {1'b0, aim_x};
    assign ay      = {1'b0, aim_y};
    assign in_box  = (ax >= xw) && (ax <= xw + BW) && (ay >= yw) && (ay <= yw + BH);
    assign cnt_inc = cnt_q + 16'd1;
    assign state   = st_q;

    // Flight step: reaching a wall exactly counts as hitting it, so clamp and bounce.
    always_comb begin
        x_fly     = duck_x;
        y_fly     = duck_y;
        dir_x_fly = dir_x;
        dir_y_fly = dir_y_up_q;
        if (!dir_x) begin
            if (xw + SX >= XR) begin
                x_fly     = XR[9:0];
                dir_x_fly = 1'b1;
            end else begin
                x_fly = 10'(xw + SX);
            end
        end else if (xw <= SX) begin
            x_fly     = '0;
            dir_x_fly = 1'b0;
        end else begin
            x_fly = 10'(xw - SX);
        end
        if (dir_y_up_q) begin
            if (yw <= SY) begin
                y_fly     = '0;
                dir_y_fly = 1'b0;
            end else begin
                y_fly = 10'(yw - SY);
            end
        end else if (yw + SY >= YF) begin
            y_fly     = YF[9:0];
            dir_y_fly = 1'b1;
        end else begin
            y_fly = 10'(yw + SY);
        end
        if (div_q == T_ANIM) begin
            div_step  = '0;
            anim_step = (duck_anim >= 2'd2) ? 2'd0 : duck_anim + 2'd1;
        end else begin
            div_step  = div_q + 16'd1;
            anim_step = duck_anim;
        end
    end

    always_comb begin
        st_d       = st_q;
        x_d        = duck_x;
        y_d        = duck_y;
        dir_x_d    = dir_x;
        dir_y_up_d = dir_y_up_q;
        last_dir_d = last_dir_q;
        anim_d     = duck_anim;
        vis_d      = duck_visible;
        hit_d      = 1'b0;
        esc_d      = 1'b0;
        cnt_d      = cnt_q;
        div_d      = div_q;
        unique case (st_q)
            S_FLY: begin
                if (shoot && in_box) begin
                    st_d   = S_HIT;
                    hit_d  = 1'b1;
                    anim_d = 2'd3;
                end else if (tick) begin
                    x_d        = x_fly;
                    y_d        = y_fly;
                    dir_x_d    = dir_x_fly;
                    dir_y_up_d = dir_y_fly;
                    anim_d     = anim_step;
                    div_d      = div_step;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == T_FLY) begin
                        st_d  = S_ESCAPE;
                        esc_d = 1'b1;
                    end
                end
            end
            S_HIT: begin
                if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == T_HIT) st_d = S_FALL;
                end
            end
            S_FALL: begin
                if (tick) begin
                    if (yw == YF) begin
                        st_d  = S_GONE;
                        vis_d = 1'b0;
                    end else begin
                        y_d = (yw + FS >= YF) ? YF[9:0] : 10'(yw + FS);
                    end
                end
            end
            S_ESCAPE: begin
                if (tick) begin
                    if (yw == '0) begin
                        st_d  = S_GONE;
                        vis_d = 1'b0;
                    end else begin
                        y_d    = (yw <= FS) ? 10'd0 : 10'(yw - FS);
                        anim_d = anim_step;
                        div_d  = div_step;
                    end
                end
            end
            S_GONE: begin
                if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == T_GONE) begin
                        st_d       = S_FLY;
                        x_d        = RX;
                        y_d        = YF[9:0];
                        dir_x_d    = ~last_dir_q;
                        last_dir_d = ~last_dir_q;
                        dir_y_up_d = 1'b1;
                        anim_d     = 2'd0;
                        vis_d      = 1'b1;
                    end
                end
            end
            default: st_d = S_FLY;
        endcase
        if (st_d != st_q) begin
            cnt_d = '0;
            div_d = '0;
        end
    end

    // Synchronizer resets high so a frame_clk level held across reset is not seen as an edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_sync      <= 2'b11;
            vs_prev      <= 1'b1;
            st_q         <= S_FLY;
            duck_x       <= RX;
            duck_y       <= YF[9:0];
            dir_x        <= 1'b0;
            dir_y_up_q   <= 1'b1;
            last_dir_q   <= 1'b0;
            duck_anim    <= 2'd0;
            duck_visible <= 1'b1;
            hit          <= 1'b0;
            escaped      <= 1'b0;
            cnt_q        <= '0;
            div_q        <= '0;
        end else begin
            vs_sync      <= {vs_sync[0], frame_clk};
            vs_prev      <= vs_sync[1];
            st_q         <= st_d;
            duck_x       <= x_d;
            duck_y       <= y_d;
            dir_x        <= dir_x_d;
            dir_y_up_q   <= dir_y_up_d;
            last_dir_q   <= last_dir_d;
            duck_anim    <= anim_d;
            duck_visible <= vis_d;
            hit          <= hit_d;
            escaped      <= esc_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
        end
    end
endmodule

// File: tb/tb_duck_flight_ctrl.sv
// tb/tb_duck_flight_ctrl.sv - self-checking bench for duck_flight_ctrl
module tb_duck_flight_ctrl;
    localparam int DUCK_W = 64, DUCK_H = 64, XR = 576, YF = 336;
    localparam int STEP_X = 2, STEP_Y = 1, FALL_STEP = 4;
    localparam int HIT_FRAMES = 30, FLY_TIMEOUT = 600, RESPAWN_FRAMES = 60;
    localparam int RESPAWN_X = 288, ANIM_DIV = 8;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       shoot = 1'b0;
    logic [9:0] aim_x = '0, aim_y = '0;
    logic [9:0] duck_x, duck_y;
    logic       dir_x, duck_visible, hit, escaped;
    logic [1:0] duck_anim;
    logic [2:0] state;

    duck_flight_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .shoot(shoot),
        .aim_x(aim_x), .aim_y(aim_y), .duck_x(duck_x), .duck_y(duck_y),
        .dir_x(dir_x), .duck_anim(duck_anim), .duck_visible(duck_visible),
        .state(state), .hit(hit), .escaped(escaped)
    );

    always #10 Clk = ~Clk;

    int n_cmp = 0, n_bad = 0;

    // Reference model: signed positions, +/-1 directions, ticks counted since state entry
    int m_x, m_y, m_dx, m_dy, m_st, m_cnt, m_t, m_base, m_anim, m_vis, m_last, m_esc = 0;

    typedef struct {
        int frames; int sh; int ax; int ay;
        int x; int y; int st; int dx; int an; int vis; int hp;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = RESPAWN_X; m_y = YF; m_dx = 1; m_dy = -1; m_st = 0;
        m_cnt = 0; m_t = 0; m_base = 0; m_anim = 0; m_vis = 1; m_last = 0;
    endtask

    task automatic model_tick();
        case (m_st)
            0: begin
                m_x = m_x + m_dx * STEP_X;
                if (m_x >= XR) begin m_x = XR; m_dx = -1; end
                else if (m_x <= 0) begin m_x = 0; m_dx = 1; end
                m_y = m_y + m_dy * STEP_Y;
                if (m_y >= YF) begin m_y = YF; m_dy = -1; end
                else if (m_y <= 0) begin m_y = 0; m_dy = 1; end
                m_t++;
                m_anim = (m_base + m_t / ANIM_DIV) % 3;
                m_cnt++;
                if (m_cnt == FLY_TIMEOUT) begin
                    m_st = 3; m_esc++; m_cnt = 0; m_t = 0; m_base = m_anim;
                end
            end
            1: begin
                m_cnt++;
                if (m_cnt == HIT_FRAMES) begin m_st = 2; m_cnt = 0; end
            end
            2: begin
                if (m_y == YF) begin m_st = 4; m_vis = 0; m_cnt = 0; end
                else m_y = (m_y + FALL_STEP > YF) ? YF : m_y + FALL_STEP;
            end
            3: begin
                if (m_y == 0) begin m_st = 4; m_vis = 0; m_cnt = 0; end
                else begin
                    m_y = (m_y - FALL_STEP < 0) ? 0 : m_y - FALL_STEP;
                    m_t++;
                    m_anim = (m_base + m_t / ANIM_DIV) % 3;
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt == RESPAWN_FRAMES) begin
                    m_last = 1 - m_last;
                    m_x = RESPAWN_X; m_y = YF; m_dx = m_last ? -1 : 1; m_dy = -1;
                    m_st = 0; m_cnt = 0; m_t = 0; m_base = 0; m_anim = 0; m_vis = 1;
                end
            end
        endcase
    endtask

    task automatic model_shoot(input int ax, input int ay, output int h);
        h = 0;
        if (m_st == 0 && ax >= m_x && ax <= m_x + DUCK_W - 1 &&
            ay >= m_y && ay <= m_y + DUCK_H - 1) begin
            m_st = 1; m_cnt = 0; m_anim = 3; h = 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".x"}, int'(duck_x), m_x);
        check({tag, ".y"}, int'(duck_y), m_y);
        check({tag, ".dir_x"}, int'(dir_x), (m_dx < 0) ? 1 : 0);
        check({tag, ".anim"}, int'(duck_anim), m_anim);
        check({tag, ".visible"}, int'(duck_visible), m_vis);
        check({tag, ".state"}, int'(state), m_st);
    endtask

    task automatic reset_dut();
        Reset_n = 1'b0; frame_clk = 1'b0; shoot = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        @(negedge Clk);
    endtask

    task automatic frame(output int h, output int e);
        h = 0; e = 0;
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) begin @(negedge Clk); h += int'(hit); e += int'(escaped); end
        frame_clk = 1'b0;
        repeat (3) begin @(negedge Clk); h += int'(hit); e += int'(escaped); end
    endtask

    task automatic do_frames(input int n);
        int h, e, th, te, e0;
        th = 0; te = 0; e0 = m_esc;
        for (int i = 0; i < n; i++) begin
            frame(h, e); th += h; te += e;
            model_tick();
        end
        if (n > 0) begin
            check("escaped_pulses", te, m_esc - e0);
            check("hit_during_frames", th, 0);
        end
    endtask

    task automatic do_shoot(input int ax, input int ay, output int hp);
        @(negedge Clk);
        shoot = 1'b1; aim_x = ax[9:0]; aim_y = ay[9:0];
        @(negedge Clk);
        hp = int'(hit);
        shoot = 1'b0;
        @(negedge Clk);
        check("hit_low_after", int'(hit), 0);
    endtask

    // Shot lands in the same Clk cycle as the frame tick
    task automatic shoot_on_tick(input int ax, input int ay, output int hp, output int esc);
        int e2;
        esc = 0;
        @(negedge Clk) frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        shoot = 1'b1; aim_x = ax[9:0]; aim_y = ay[9:0];
        @(negedge Clk);
        hp = int'(hit); esc = int'(escaped);
        shoot = 1'b0;
        @(negedge Clk) esc += int'(escaped);
        frame_clk = 1'b0;
        repeat (3) begin @(negedge Clk); esc += int'(escaped); end
        model_shoot(ax, ay, e2);
        if (e2 == 0) model_tick();
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hp, esc, r, ax, ay, exp_h;

        //         frames sh ax   ay   x    y    st dx an vis hp
        tbl[0]  = '{0,   0, 0,   0,   288, 336, 0, 0, 0, 1, 0};
        tbl[1]  = '{0,   1, 287, 336, 288, 336, 0, 0, 0, 1, 0};
        tbl[2]  = '{0,   1, 300, 400, 288, 336, 0, 0, 0, 1, 0};
        tbl[3]  = '{10,  0, 0,   0,   308, 326, 0, 0, 1, 1, 0};
        tbl[4]  = '{134, 0, 0,   0,   576, 192, 0, 1, 0, 1, 0};
        tbl[5]  = '{1,   0, 0,   0,   574, 191, 0, 1, 0, 1, 0};
        tbl[6]  = '{0,   1, 574, 191, 574, 191, 1, 1, 3, 1, 1};
        tbl[7]  = '{30,  0, 0,   0,   574, 191, 2, 1, 3, 1, 0};
        tbl[8]  = '{1,   0, 0,   0,   574, 195, 2, 1, 3, 1, 0};
        tbl[9]  = '{36,  0, 0,   0,   574, 336, 2, 1, 3, 1, 0};
        tbl[10] = '{1,   0, 0,   0,   574, 336, 4, 1, 3, 0, 0};
        tbl[11] = '{59,  0, 0,   0,   574, 336, 4, 1, 3, 0, 0};
        tbl[12] = '{1,   0, 0,   0,   288, 336, 0, 1, 0, 1, 0};
        tbl[13] = '{1,   0, 0,   0,   286, 335, 0, 1, 0, 1, 0};

        reset_dut();
        check("reset.hit", int'(hit), 0);
        check("reset.escaped", int'(escaped), 0);
        for (int i = 0; i < 14; i++) begin
            do_frames(tbl[i].frames);
            if (tbl[i].sh != 0) begin
                do_shoot(tbl[i].ax, tbl[i].ay, hp);
                model_shoot(tbl[i].ax, tbl[i].ay, exp_h);
                check($sformatf("vec%0d.hit", i), hp, tbl[i].hp);
            end
            check($sformatf("vec%0d.x", i), int'(duck_x), tbl[i].x);
            check($sformatf("vec%0d.y", i), int'(duck_y), tbl[i].y);
            check($sformatf("vec%0d.state", i), int'(state), tbl[i].st);
            check($sformatf("vec%0d.dir_x", i), int'(dir_x), tbl[i].dx);
            check($sformatf("vec%0d.anim", i), int'(duck_anim), tbl[i].an);
            check($sformatf("vec%0d.visible", i), int'(duck_visible), tbl[i].vis);
        end

        // Hit at the bottom-right corner of the box, fall from the ground line, respawn
        reset_dut();
        do_shoot(351, 399, hp);
        check("corner.hit", hp, 1);
        check("corner.state", int'(state), 1);
        do_frames(30);
        check("corner.fall_state", int'(state), 2);
        check("corner.fall_y", int'(duck_y), 336);
        do_frames(1);
        check("corner.gone_state", int'(state), 4);
        check("corner.gone_visible", int'(duck_visible), 0);
        do_frames(60);
        check("corner.respawn_x", int'(duck_x), 288);
        check("corner.respawn_y", int'(duck_y), 336);
        check("corner.respawn_dir", int'(dir_x), 1);
        check("corner.respawn_state", int'(state), 0);

        // Shot and tick in the same cycle: pre-tick position, no motion
        reset_dut();
        do_frames(5);
        shoot_on_tick(298, 331, hp, esc);
        check("same_cycle.hit", hp, 1);
        check("same_cycle.state", int'(state), 1);
        check("same_cycle.x", int'(duck_x), 298);
        check("same_cycle.y", int'(duck_y), 331);

        // Timeout, escape climb, gone
        reset_dut();
        do_frames(599);
        check("timeout.pre_state", int'(state), 0);
        do_frames(1);
        check("timeout.state", int'(state), 3);
        check("timeout.x", int'(duck_x), 336);
        check("timeout.y", int'(duck_y), 264);
        check_model("timeout");
        do_frames(66);
        check("escape.y", int'(duck_y), 0);
        check("escape.state", int'(state), 3);
        do_frames(1);
        check("escape.gone_state", int'(state), 4);
        check("escape.gone_visible", int'(duck_visible), 0);

        // Hit coinciding with the timeout tick: hit wins
        reset_dut();
        do_frames(599);
        shoot_on_tick(334, 263, hp, esc);
        check("timeout_hit.hit", hp, 1);
        check("timeout_hit.escaped", esc, 0);
        check("timeout_hit.state", int'(state), 1);

        // Asynchronous reset mid-FALL with a tick pending
        reset_dut();
        do_frames(20);
        do_shoot(328, 316, hp);
        check("midfall.hit", hp, 1);
        do_frames(32);
        check("midfall.y", int'(duck_y), 324);
        check("midfall.state", int'(state), 2);
        @(negedge Clk) frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("async.x", int'(duck_x), 288);
        check("async.y", int'(duck_y), 336);
        check("async.state", int'(state), 0);
        check("async.dir_x", int'(dir_x), 0);
        check("async.anim", int'(duck_anim), 0);
        check("async.visible", int'(duck_visible), 1);
        @(negedge Clk) Reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check("async.no_motion_x", int'(duck_x), 288);
        check("async.no_motion_y", int'(duck_y), 336);

        // Randomized frames and shots against the model
        reset_dut();
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                if ($urandom_range(0, 1) == 1) begin
                    ax = m_x + int'($urandom_range(0, 80)) - 8;
                    ay = m_y + int'($urandom_range(0, 80)) - 8;
                end else begin
                    ax = int'($urandom_range(0, 1023));
                    ay = int'($urandom_range(0, 1023));
                end
                ax = (ax < 0) ? 0 : (ax > 1023) ? 1023 : ax;
                ay = (ay < 0) ? 0 : (ay > 1023) ? 1023 : ay;
                model_shoot(ax, ay, exp_h);
                do_shoot(ax, ay, hp);
                check("rnd.hit", hp, exp_h);
            end else begin
                do_frames(int'($urandom_range(1, 12)));
            end
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/duck_flight_ctrl.md
# duck_flight_ctrl

Per-frame motion and life-cycle controller for one duck sprite. Advances the duck's screen position once per video frame, derived from the rising edge of `VGA_VS`. Resolves shots against the duck's bounding box and sequences fly → hit → fall → gone → respawn, or fly → escape → gone → respawn. Sits directly upstream of the duck sprite/address generator: its position, animation-frame, direction and visibility outputs feed that block, and the color mapper consumes the result.

## Interface
Parameters:
- `DUCK_W`, 64: sprite width in pixels.
- `DUCK_H`, 64: sprite height in pixels.
- `X_MAX`, 639: rightmost flight pixel.
- `Y_MAX`, 399: lowest flight pixel, the ground line.
- `STEP_X`, 2: horizontal pixels per frame while flying.
- `STEP_Y`, 1: vertical pixels per frame while flying.
- `FALL_STEP`, 4: pixels per frame while falling or escaping.
- `HIT_FRAMES`, 30: frames frozen after a hit.
- `FLY_TIMEOUT`, 600: frames of flight before escape.
- `RESPAWN_FRAMES`, 60: frames spent in GONE.
- `RESPAWN_X`, 288: x position at reset and respawn.
- `ANIM_DIV`, 8: frames per wing-animation step.

Ports:
- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: reset, asynchronous, active-low.
- `frame_clk` in 1: `VGA_VS` level.
- `shoot` in 1: trigger, one-`Clk` pulse.
- `aim_x`, `aim_y` in 10 each: crosshair pixel position, valid while `shoot`=1.
- `duck_x`, `duck_y` out 10 each: sprite top-left corner.
- `dir_x` out 1: 0 = moving right, 1 = moving left.
- `duck_anim` out 2: sprite frame select.
- `duck_visible` out 1: sprite enable.
- `state` out 3: FLY=0, HIT=1, FALL=2, ESCAPE=3, GONE=4.
- `hit` out 1: one-cycle pulse on a successful shot.
- `escaped` out 1: one-cycle pulse on a flight timeout.

## Operation
- Derived bounds: `XR = X_MAX+1-DUCK_W` (576) and `YF = Y_MAX+1-DUCK_H` (336). All position arithmetic is 11-bit with explicit clamping; 10-bit outputs never wrap.
- Frame tick: `frame_clk` passes a 2-FF synchronizer, then rising-edge detection; `tick` is high for exactly one `Clk` cycle per frame.
- Reset values: `duck_x=RESPAWN_X`, `duck_y=YF`, `dir_x=0`, internal `dir_y`=up, `state=FLY`, `duck_anim=0`, `duck_visible=1`, `hit=0`, `escaped=0`, all frame counters 0.
- FLY, on tick:
  - x moves by `STEP_X`; if the next x would pass 0 or XR, x is clamped to that bound and `dir_x` flips in the same tick.
  - y moves by `STEP_Y` within [0, YF] using the same clamp-and-flip rule.
  - The flight counter increments; when it reaches `FLY_TIMEOUT`, the state goes to ESCAPE and `escaped` pulses.
- Shot resolution, FLY only:
  - Hit when `duck_x ≤ aim_x ≤ duck_x+DUCK_W-1` and `duck_y ≤ aim_y ≤ duck_y+DUCK_H-1`, tested against the current registered position.
  - A hit moves the state to HIT, pulses `hit`, and clears the frame counter.
  - A miss, or a shot in any other state, is ignored.
- HIT: position frozen and `duck_anim=3`; after `HIT_FRAMES` ticks the state goes to FALL.
- FALL: on each tick, `duck_y = min(duck_y+FALL_STEP, YF)`; `duck_anim=3`. A tick arriving with `duck_y==YF` moves the state to GONE.
- ESCAPE: on each tick, `duck_y = max(duck_y-FALL_STEP, 0)`; x frozen. A tick arriving with `duck_y==0` moves the state to GONE.
- GONE: `duck_visible=0`. After `RESPAWN_FRAMES` ticks, all registers return to their reset values, except `dir_x`, which is the inverse of its value at the last respawn.
- Animation: in FLY and ESCAPE, `duck_anim` steps 0→1→2→0 every `ANIM_DIV` ticks. The animation divider resets on every state change.

## Timing
- `tick` rises 2–3 `Clk` cycles after the `frame_clk` rising edge.
- All outputs are registered and update on the `Clk` edge where `tick`=1.
- Shot latency: on the `Clk` edge that samples `shoot`=1, `state=HIT` and `hit=1` together; `hit` is low on the following cycle.
- `shoot` and `tick` in the same cycle: the hit test uses the pre-tick position; a hit wins and no motion is applied that cycle.
- Timeout tick and hit in the same cycle: the hit wins and `escaped` is not pulsed.
- `Reset_n` low at any time, including mid-FALL or mid-GONE: all outputs take their reset values immediately (asynchronous). A pending tick is discarded.

## Test plan
- Reset, then 10 frames → `duck_x=308`, `duck_y=326`, `state=0`, `duck_anim=1`.
- Right wall: 144 frames from reset → `duck_x=576`, `dir_x=1`; frame 145 → `duck_x=574`.
- Shot hit: from reset, `shoot` with aim (351,399) → `hit` pulse and `state=1`. Freeze for 30 frames, then y steps 336 held (already at YF) → GONE on the next tick. After 60 frames, respawn at (288,336) with `dir_x=1`.
- Shot miss: aim (287,336) and aim (300,400) → no state change, no `hit`.
- Timeout: 600 frames with no shot → `escaped` pulse, y falls by 4 per frame to 0, GONE, `duck_visible=0`.
- Async reset asserted mid-FALL between `Clk` edges → outputs at reset values before the next edge; `tick` coincident with deassertion causes no motion.
